// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an active-low seven-segment bus that
//   is shared by DIGITS digit positions. Only one anode is enabled at a time.
//   Each slot begins with a blanking gap that suppresses ghosting. The
//   displayed value is kept in a shadow register. That register is reloaded
//   from the requester only at frame boundaries, through a Load/Ack handshake.
//
// Ports
//   Clock     in   system clock, rising edge
//   Reset     in   synchronous active-low reset
//   Load      in   requester wants the display value replaced (held until Ack)
//   Value     in   DIGITS BCD nibbles, nibble 0 = least significant digit
//   Blank_Lz  in   1 = suppress leading zeros (sampled live, not shadowed)
//   Seg       out  segments gfedcba, active-low, registered
//   Anode     out  digit enables, active-low, registered, at most one low
//   Ack       out  one-cycle pulse: Value captured into the shadow register
//   Frame     out  one-cycle pulse following the last cycle of each frame
// ----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic                  Blank_Lz,
    output logic [6:0]            Seg,
    output logic [DIGITS-1:0]     Anode,
    output logic                  Ack,
    output logic                  Frame
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? SW'(BLANK_CYC - 1) : '0;
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [SW-1:0] SLOT_ONE   = SW'(1);
    localparam logic [DW-1:0] DIGIT_ONE  = DW'(1);

    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    // A slot starts in SHOW directly when no blanking gap is configured.
    localparam phase_e PH_SLOT_START = (BLANK_CYC > 0) ? PH_BLANK : PH_SHOW;

    // BCD to active-low gfedcba; non-decimal nibbles render as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg_v;
        case (nib)
            4'd0:    seg_v = 7'b1000000;
            4'd1:    seg_v = 7'b1111001;
            4'd2:    seg_v = 7'b0100100;
            4'd3:    seg_v = 7'b0110000;
            4'd4:    seg_v = 7'b0011001;
            4'd5:    seg_v = 7'b0010010;
            4'd6:    seg_v = 7'b0000010;
            4'd7:    seg_v = 7'b1111000;
            4'd8:    seg_v = 7'b0000000;
            4'd9:    seg_v = 7'b0010000;
            default: seg_v = 7'b0111111;
        endcase
        return seg_v;
    endfunction

    logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]         digit_q,    digit_d;
    logic [4*DIGITS-1:0]   shadow_q,   shadow_d;
    phase_e                phase_q,    phase_d;
    logic [6:0]            seg_q,      seg_d;
    logic [DIGITS-1:0]     anode_q,    anode_d;
    logic                  ack_q,      ack_d;
    logic                  frame_q,    frame_d;

    logic                  slot_end_s;
    logic                  boundary_s;
    logic [3:0]            cur_nib_s;
    logic                  lz_zero_s;
    logic                  suppress_s;

    // Slot/digit counters and the frame-boundary capture of the shadow value.
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        digit_d    = digit_q;
        shadow_d   = shadow_q;
        ack_d      = 1'b0;
        frame_d    = 1'b0;
        slot_end_s = (slot_cnt_q == SCAN_LAST);
        boundary_s = slot_end_s && (digit_q == DIGIT_LAST);

        if (slot_end_s) begin
            slot_cnt_d = '0;
            if (digit_q == DIGIT_LAST) begin
                digit_d = '0;
            end else begin
                digit_d = digit_q + DIGIT_ONE;
            end
        end else begin
            slot_cnt_d = slot_cnt_q + SLOT_ONE;
        end

        // Load is only honoured here, so the shadow never changes mid-frame.
        if (boundary_s) begin
            frame_d = 1'b1;
            if (Load) begin
                shadow_d = Value;
                ack_d    = 1'b1;
            end else begin
                ack_d    = 1'b0;
            end
        end else begin
            frame_d = 1'b0;
        end
    end

    // Phase FSM next state: BLANK for the first BLANK_CYC counts of a slot.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_BLANK: begin
                if (slot_end_s) begin
                    phase_d = PH_SLOT_START;
                end else if (slot_cnt_q == BLANK_LAST) begin
                    phase_d = PH_SHOW;
                end else begin
                    phase_d = PH_BLANK;
                end
            end
            PH_SHOW: begin
                if (slot_end_s) begin
                    phase_d = PH_SLOT_START;
                end else begin
                    phase_d = PH_SHOW;
                end
            end
            default: phase_d = PH_SLOT_START;
        endcase
    end

    // Nibble of the active digit and the leading-zero test over digit..top.
    always_comb begin
        cur_nib_s = 4'd0;
        lz_zero_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                cur_nib_s = shadow_q[4*i +: 4];
            end else begin
                cur_nib_s = cur_nib_s;
            end
            if ((DW'(i) >= digit_q) && (shadow_q[4*i +: 4] != 4'd0)) begin
                lz_zero_s = 1'b0;
            end else begin
                lz_zero_s = lz_zero_s;
            end
        end
        suppress_s = Blank_Lz && (digit_q != '0) && lz_zero_s;
    end

    // Output drive for the next cycle: dark unless showing an unsuppressed digit.
    always_comb begin
        seg_d   = 7'b1111111;
        anode_d = '1;
        if ((phase_q == PH_SHOW) && !suppress_s) begin
            seg_d = seg_decode(cur_nib_s);
            for (int i = 0; i < DIGITS; i++) begin
                if (digit_q == DW'(i)) begin
                    anode_d[i] = 1'b0;
                end else begin
                    anode_d[i] = 1'b1;
                end
            end
        end else begin
            seg_d   = 7'b1111111;
            anode_d = '1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            slot_cnt_q <= '0;
            digit_q    <= '0;
            shadow_q   <= '0;
            phase_q    <= PH_SLOT_START;
            seg_q      <= 7'b1111111;
            anode_q    <= '1;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
            shadow_q   <= shadow_d;
            phase_q    <= phase_d;
            seg_q      <= seg_d;
            anode_q    <= anode_d;
            ack_q      <= ack_d;
            frame_q    <= frame_d;
        end
    end

    assign Seg   = seg_q;
    assign Anode = anode_q;
    assign Ack   = ack_q;
    assign Frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
//   cyc tracks the counter cycle; cycle 0 is the first cycle with Reset=1.
//   Outputs are checked 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Load;
    logic [15:0] Value;
    logic        Blank_Lz;
    logic [6:0]  Seg;
    logic [3:0]  Anode;
    logic        Ack;
    logic        Frame;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 Clock = ~Clock;

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (Load),
        .Value    (Value),
        .Blank_Lz (Blank_Lz),
        .Seg      (Seg),
        .Anode    (Anode),
        .Ack      (Ack),
        .Frame    (Frame)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] anode_exp, input logic [6:0] seg_exp);
        chk({tag, "_anode"}, {12'd0, Anode}, {12'd0, anode_exp});
        chk({tag, "_seg"},   {9'd0, Seg},    {9'd0, seg_exp});
    endtask

    task automatic chk_pulses(input string tag, input logic ack_exp, input logic frame_exp);
        chk({tag, "_ack"},   {15'd0, Ack},   {15'd0, ack_exp});
        chk({tag, "_frame"}, {15'd0, Frame}, {15'd0, frame_exp});
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Checks the SCAN_DIV-BLANK_CYC visible cycles of one slot starting at first.
    task automatic chk_slot(input string tag, input int first, input logic [3:0] anode_exp,
                            input logic [6:0] seg_exp);
        for (int c = first; c < first + SCAN_DIV - BLANK_CYC; c++) begin
            run_to(c);
            chk_out(tag, anode_exp, seg_exp);
        end
    endtask

    initial begin
        Reset    = 1'b0;
        Load     = 1'b0;
        Value    = 16'h0000;
        Blank_Lz = 1'b0;

        // Reset held for three edges: everything dark and quiet.
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            chk_out("reset", 4'b1111, 7'b1111111);
            chk_pulses("reset", 1'b0, 1'b0);
        end

        // Cycle 0: first cycle with Reset=1, request 1234 pending.
        Reset = 1'b1;
        Load  = 1'b1;
        Value = 16'h1234;
        cyc   = 0;
        chk_out("release", 4'b1111, 7'b1111111);
        chk_pulses("release", 1'b0, 1'b0);

        for (int c = 1; c < 32; c++) begin
            tick();
            chk_pulses("pre_boundary", 1'b0, 1'b0);
        end
        tick();                                   // cycle 32
        chk_pulses("first_boundary", 1'b1, 1'b1);
        Load = 1'b0;
        tick();                                   // cycle 33
        chk_pulses("after_boundary", 1'b0, 1'b0);
        tick();                                   // cycle 34, still in gap
        chk_out("d0_gap", 4'b1111, 7'b1111111);

        chk_slot("d0_4", 35, 4'b1110, 7'b0011001);
        tick();                                   // cycle 41, digit 1 gap
        chk_out("d1_gap", 4'b1111, 7'b1111111);
        chk_slot("d1_3", 43, 4'b1101, 7'b0110000);
        chk_slot("d2_2", 51, 4'b1011, 7'b0100100);
        chk_slot("d3_1", 59, 4'b0111, 7'b1111001);
        chk_pulses("frame2", 1'b0, 1'b1);         // cycle 64, Load low

        // Load 0050 with leading-zero suppression.
        Load     = 1'b1;
        Value    = 16'h0050;
        Blank_Lz = 1'b1;
        run_to(95);
        chk_pulses("pre_ack_0050", 1'b0, 1'b0);
        run_to(96);
        chk_pulses("ack_0050", 1'b1, 1'b1);
        Load = 1'b0;
        chk_slot("lz_d0", 99, 4'b1110, 7'b1000000);
        chk_slot("lz_d1", 107, 4'b1101, 7'b0010010);
        chk_slot("lz_d2", 115, 4'b1111, 7'b1111111);
        chk_slot("lz_d3", 123, 4'b1111, 7'b1111111);

        // Same value, suppression off.
        Blank_Lz = 1'b0;
        chk_slot("nolz_d3", 155, 4'b0111, 7'b1000000);

        // Cycle 160: load A000, captured at boundary 191.
        Load  = 1'b1;
        Value = 16'hA000;
        run_to(192);
        chk_pulses("ack_a000", 1'b1, 1'b1);
        Load = 1'b0;
        chk_slot("dash_d3", 219, 4'b0111, 7'b0111111);

        // Load pulsed inside frame 224..255 (cycles 5..10): ignored.
        run_to(229);
        Load  = 1'b1;
        Value = 16'h9999;
        run_to(235);
        Load = 1'b0;
        run_to(256);
        chk_pulses("no_ack", 1'b0, 1'b1);
        chk_slot("kept_d0", 259, 4'b1110, 7'b1000000);
        chk_slot("kept_d3", 283, 4'b0111, 7'b0111111);

        // Load held, reset pulsed at frame cycle 20 (absolute 308).
        run_to(296);
        Load  = 1'b1;
        Value = 16'h5678;
        run_to(308);
        Reset = 1'b0;
        tick();                                   // cycle 309 = new cycle 0
        Reset = 1'b1;
        chk_out("post_reset", 4'b1111, 7'b1111111);
        chk_pulses("post_reset", 1'b0, 1'b0);
        for (int c = 310; c < 336; c++) begin
            tick();
            chk_pulses("pending", 1'b0, 1'b0);
        end
        // Shadow cleared: digit 3 shows 0 instead of the earlier dash.
        chk_slot("rst_d3", 336, 4'b0111, 7'b1000000);
        chk_pulses("ack_after_reset", 1'b1, 1'b1); // cycle 341
        Load = 1'b0;
        chk_slot("rst_d0_8", 344, 4'b1110, 7'b0000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
